// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity and stop-bit
// mode constants, and the expected-parity helper used by the receiver.
package uart_pkg;

    // One-hot receiver states, matching the transmitter FSM encoding style
    typedef enum logic [5:0] {
        LINE_WAIT = 6'b000001,
        IDLE      = 6'b000010,
        START     = 6'b000100,
        DATA      = 6'b001000,
        PARITY    = 6'b010000,
        STOP      = 6'b100000
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b11;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    // Parity bit a correct transmitter sends: XOR of the data for even
    // parity, its complement for odd parity
    function automatic logic expectedParity(input logic [7:0] data, input logic [1:0] mode);
        return (^data) ^ ~mode[1];
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high input.
// Flops reset to 1 so a serial line reads idle straight out of reset.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_stages;

    // Shift the raw input through the flop chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stages <= '1;
        end else begin
            r_stages <= {r_stages[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop decoding with break
// detection and a valid-ready output register with overrun reporting.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// vote around the bit centre instead of a single centre sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OS_RATE     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_os_tick,
    input  logic [1:0] i_parity_mode,
    input  logic       i_frame_mode,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_ready,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_break,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int CW = $clog2(OS_RATE);

    // With voting the decision lands one tick after the centre; START is
    // shifted by one tick, so every later bit window shifts with it and the
    // same OS_RATE-1 decision point in DATA/PARITY/STOP stays centre+1.
`ifdef UART_RX_MAJORITY_EN
    localparam int START_LAST = OS_RATE / 2;
`else
    localparam int START_LAST = OS_RATE / 2 - 1;
`endif

    localparam logic [CW-1:0] START_LAST_C = CW'(START_LAST);
    localparam logic [CW-1:0] BIT_LAST_C   = CW'(OS_RATE - 1);

    logic            w_rxS;
    rx_state_t       r_state;
    rx_state_t       w_nextState;
    logic [CW-1:0]   r_osCnt;
    logic [CW-1:0]   w_last;
    logic [2:0]      r_bitCnt;
    logic            r_stopCnt;
    logic [7:0]      r_shift;
    logic            r_parErr;
    logic            r_parBitZero;
    logic            r_frameErr;
    logic            r_stop1Zero;
    logic            w_decide;
    logic            w_sample;
    logic            w_frameDone;
    logic            w_isBreak;
    logic            w_firstStopZero;
    logic            w_frameErrFinal;

    logic [7:0]      r_dataOut;
    logic            r_validOut;
    logic            r_parErrOut;
    logic            r_frameErrOut;
    logic            r_breakOut;
    logic            r_overrunOut;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (i_rx),
        .o_sync  (w_rxS)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous tick samples for the 2-of-3 vote
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hist <= 2'b11;
        end else if (i_os_tick) begin
            r_hist <= {r_hist[0], w_rxS};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxS) | (r_hist[0] & w_rxS);
`else
    assign w_sample = w_rxS;
`endif

    // Bit decision point and frame-level flags derived from the current sample
    always_comb begin
        w_last          = (r_state == START) ? START_LAST_C : BIT_LAST_C;
        w_decide        = i_os_tick && (r_osCnt == w_last) &&
                          (r_state inside {START, DATA, PARITY, STOP});
        w_firstStopZero = (r_stopCnt == 1'b0) ? ~w_sample : r_stop1Zero;
        w_isBreak       = (r_shift == 8'h00) && (!i_parity_mode[0] || r_parBitZero) &&
                          w_firstStopZero;
        w_frameErrFinal = r_frameErr | ~w_sample;
    end

    // Next-state logic; a break frame parks in LINE_WAIT until the line idles
    always_comb begin
        w_nextState = r_state;
        w_frameDone = 1'b0;
        case (r_state)
            LINE_WAIT: if (i_os_tick && w_rxS) w_nextState = IDLE;
            IDLE:      if (i_os_tick && !w_rxS) w_nextState = START;
            START:     if (w_decide) w_nextState = w_sample ? IDLE : DATA;
            DATA: begin
                if (w_decide && r_bitCnt == 3'd7) begin
                    w_nextState = i_parity_mode[0] ? PARITY : STOP;
                end
            end
            PARITY:    if (w_decide) w_nextState = STOP;
            STOP: begin
                if (w_decide && r_stopCnt == i_frame_mode) begin
                    w_frameDone = 1'b1;
                    w_nextState = w_isBreak ? LINE_WAIT : IDLE;
                end
            end
            default:   w_nextState = LINE_WAIT;
        endcase
    end

    // State register; reset aborts any partial frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= LINE_WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Oversample counter, shift register and per-frame error tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_osCnt      <= '0;
            r_bitCnt     <= 3'd0;
            r_stopCnt    <= 1'b0;
            r_shift      <= 8'h00;
            r_parErr     <= 1'b0;
            r_parBitZero <= 1'b0;
            r_frameErr   <= 1'b0;
            r_stop1Zero  <= 1'b0;
        end else if (i_os_tick) begin
            if (w_nextState != r_state || r_osCnt == BIT_LAST_C) begin
                r_osCnt <= '0;
            end else begin
                r_osCnt <= r_osCnt + 1'b1;
            end
            if (w_decide) begin
                case (r_state)
                    START: begin
                        r_bitCnt     <= 3'd0;
                        r_stopCnt    <= 1'b0;
                        r_parErr     <= 1'b0;
                        r_parBitZero <= 1'b0;
                        r_frameErr   <= 1'b0;
                        r_stop1Zero  <= 1'b0;
                    end
                    DATA: begin
                        r_shift  <= {w_sample, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                    end
                    PARITY: begin
                        r_parErr     <= (w_sample != expectedParity(r_shift, i_parity_mode));
                        r_parBitZero <= ~w_sample;
                    end
                    STOP: begin
                        if (!w_sample) r_frameErr <= 1'b1;
                        if (r_stopCnt == 1'b0) r_stop1Zero <= ~w_sample;
                        r_stopCnt <= r_stopCnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output register: load on completion if free or being drained, else drop and flag overrun
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dataOut     <= 8'h00;
            r_validOut    <= 1'b0;
            r_parErrOut   <= 1'b0;
            r_frameErrOut <= 1'b0;
            r_breakOut    <= 1'b0;
            r_overrunOut  <= 1'b0;
        end else begin
            r_overrunOut <= 1'b0;
            if (w_frameDone) begin
                if (!r_validOut || i_ready) begin
                    r_validOut    <= 1'b1;
                    r_dataOut     <= w_isBreak ? 8'h00 : r_shift;
                    r_breakOut    <= w_isBreak;
                    r_frameErrOut <= w_isBreak | w_frameErrFinal;
                    r_parErrOut   <= w_isBreak ? 1'b0 : r_parErr;
                end else begin
                    r_overrunOut <= 1'b1;
                end
            end else if (r_validOut && i_ready) begin
                r_validOut <= 1'b0;
            end
        end
    end

    assign o_data       = r_dataOut;
    assign o_data_valid = r_validOut;
    assign o_parity_err = r_parErrOut;
    assign o_frame_err  = r_frameErrOut;
    assign o_break      = r_breakOut;
    assign o_overrun    = r_overrunOut;
    assign o_busy       = !(r_state inside {IDLE, LINE_WAIT});

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames with i_ready high,
// then hand-written sequences for reset-low line, glitch, break and overrun.
module tb_uart_rx;

    localparam int OS_RATE  = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS_RATE * TICK_DIV;

    logic       clk;
    logic       rstn;
    logic       i_os_tick;
    logic [1:0] i_parity_mode;
    logic       i_frame_mode;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       i_ready;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_break;
    logic       o_overrun;
    logic       o_busy;

    int nChecks = 0;
    int nPass   = 0;
    int overrunCount = 0;
    int tickCnt = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } beat_t;

    beat_t beats[$];

    typedef struct {
        logic [7:0] data;
        logic [1:0] parMode;
        logic       frameMode;
        logic       parBit;
        logic       stop2;
        logic [7:0] expData;
        logic       expParErr;
        logic       expFrameErr;
    } vec_t;

    vec_t vecs[8];

    uart_rx #(
        .OS_RATE     (OS_RATE),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_os_tick     (i_os_tick),
        .i_parity_mode (i_parity_mode),
        .i_frame_mode  (i_frame_mode),
        .i_rx          (i_rx),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .i_ready       (i_ready),
        .o_parity_err  (o_parity_err),
        .o_frame_err   (o_frame_err),
        .o_break       (o_break),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample tick every TICK_DIV clocks, standing in for the baud generator
    always @(posedge clk) begin
        tickCnt   <= (tickCnt == TICK_DIV - 1) ? 0 : tickCnt + 1;
        i_os_tick <= (tickCnt == TICK_DIV - 1);
    end

    // Record every accepted beat and every overrun pulse, away from the active edge
    always @(negedge clk) begin
        if (o_data_valid && i_ready) begin
            beats.push_back('{o_data, o_parity_err, o_frame_err, o_break});
        end
        if (o_overrun) overrunCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        i_rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic hasPar, input logic parBit,
                                 input logic twoStop, input logic stop2);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        if (hasPar) sendBit(parBit);
        sendBit(1'b1);
        if (twoStop) sendBit(stop2);
        sendBit(1'b1);
    endtask

    task automatic checkBeat(input string name, input logic [7:0] d, input logic pe,
                             input logic fe, input logic brk);
        beat_t b;
        checkOutput({name, " beats"}, beats.size(), 1);
        if (beats.size() > 0) begin
            b = beats.pop_front();
            checkOutput({name, " data"}, b.d, d);
            checkOutput({name, " parity_err"}, b.pe, pe);
            checkOutput({name, " frame_err"}, b.fe, fe);
            checkOutput({name, " break"}, b.brk, brk);
        end
        beats.delete();
    endtask

    initial begin
        rstn          = 1'b0;
        i_rx          = 1'b0;
        i_ready       = 1'b1;
        i_parity_mode = 2'b00;
        i_frame_mode  = 1'b0;

        vecs[0] = '{8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 2'b01, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 2'b00, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h5A, 2'b11, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 2'b01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};

        // Reset values, with the line held low across reset
        repeat (5) @(posedge clk);
        #2;
        checkOutput("reset data", o_data, 8'h00);
        checkOutput("reset valid", o_data_valid, 1'b0);
        checkOutput("reset flags", {o_parity_err, o_frame_err, o_break, o_overrun}, 4'b0000);
        checkOutput("reset busy", o_busy, 1'b0);
        rstn = 1'b1;

        // Line still low after reset must not start a frame
        repeat (2 * BIT_CLKS) @(posedge clk);
        #2;
        checkOutput("low-after-reset busy", o_busy, 1'b0);
        checkOutput("low-after-reset beats", beats.size(), 0);
        sendBit(1'b1);
        sendBit(1'b1);

        // Table of single frames, consumer always ready
        for (int v = 0; v < 8; v++) begin
            i_parity_mode = vecs[v].parMode;
            i_frame_mode  = vecs[v].frameMode;
            applyStimulus(vecs[v].data, vecs[v].parMode[0], vecs[v].parBit,
                          vecs[v].frameMode, vecs[v].stop2);
            checkBeat($sformatf("vec%0d", v), vecs[v].expData, vecs[v].expParErr,
                      vecs[v].expFrameErr, 1'b0);
            checkOutput($sformatf("vec%0d busy", v), o_busy, 1'b0);
        end

        // Glitch: line low for 4 ticks only
        i_parity_mode = 2'b00;
        i_frame_mode  = 1'b0;
        i_rx = 1'b0;
        repeat (4 * TICK_DIV) @(posedge clk);
        #2;
        checkOutput("glitch busy during", o_busy, 1'b1);
        i_rx = 1'b1;
        repeat (8 * TICK_DIV) @(posedge clk);
        #2;
        checkOutput("glitch busy after", o_busy, 1'b0);
        sendBit(1'b1);
        checkOutput("glitch beats", beats.size(), 0);

        // Break: 11 low bits with odd parity, line kept low for 2 more bits
        i_parity_mode = 2'b01;
        for (int i = 0; i < 13; i++) sendBit(1'b0);
        checkBeat("break", 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("break busy", o_busy, 1'b0);
        sendBit(1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        checkBeat("after-break", 8'h3C, 1'b0, 1'b0, 1'b0);

        // Overrun: consumer stalled across two frames
        checkOutput("no overrun so far", overrunCount, 0);
        i_parity_mode = 2'b00;
        i_ready = 1'b0;
        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("hold valid", o_data_valid, 1'b1);
        checkOutput("hold data", o_data, 8'h11);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("overrun data kept", o_data, 8'h11);
        checkOutput("overrun valid kept", o_data_valid, 1'b1);
        checkOutput("overrun pulse count", overrunCount, 1);
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("drain valid", o_data_valid, 1'b0);
        checkBeat("drain", 8'h11, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
